// File: rtl/arb_pkg.sv
// Shared types and default sizing for the N-port memory arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_e;

   localparam int ARB_NUM_PORTS = 3;
   localparam int ARB_WIDTH     = 256;

endpackage

// File: rtl/rr_picker.sv
// Winner selection: first requesting port at or after ptr_i, wrapping modulo NUM_PORTS.
module rr_picker #(
   parameter int NUM_PORTS = 3,
   parameter int IW        = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [IW-1:0]        ptr_i,
   output logic [NUM_PORTS-1:0] grant_o,
   output logic [IW-1:0]        idx_o,
   output logic                 vld_o
);

   always_comb begin
      int c;
      grant_o = '0;
      idx_o   = '0;
      vld_o   = 1'b0;
      c       = 0;
      // Scan from the farthest offset down so the nearest requester wins.
      for (int off = NUM_PORTS - 1; off >= 0; off--) begin
         c = int'(ptr_i) + off;
         if (c >= NUM_PORTS) c = c - NUM_PORTS;
         if (req_i[c]) begin
            grant_o    = '0;
            grant_o[c] = 1'b1;
            idx_o      = IW'(c);
            vld_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-port cache-to-L2 arbiter, one transaction at a time (IDLE -> BUSY -> DONE).
// Define ARB_ROUND_ROBIN_EN for rotating priority; default is fixed priority, port 0 first.
module mem_arbiter_n
   import arb_pkg::*;
#(
   parameter int NUM_PORTS = ARB_NUM_PORTS,
   parameter int WIDTH     = ARB_WIDTH
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_PORTS-1:0]                 req_read,
   input  logic [NUM_PORTS-1:0]                 req_write,
   input  logic [NUM_PORTS-1:0][31:0]           req_address,
   input  logic [NUM_PORTS-1:0][WIDTH-1:0]      req_wdata,
   output logic [WIDTH-1:0]                     req_rdata,
   output logic [NUM_PORTS-1:0]                 req_resp,
   output logic                                 mem_read,
   output logic                                 mem_write,
   output logic [31:0]                          mem_address,
   output logic [WIDTH-1:0]                     mem_wdata,
   input  logic [WIDTH-1:0]                     mem_rdata,
   input  logic                                 mem_resp
);

   localparam int IW = $clog2(NUM_PORTS);

   arb_state_e        state_q, state_d;
   logic [IW-1:0]     gidx_q, gidx_d;
   logic              wr_q, wr_d;
   logic [31:0]       addr_q, addr_d;
   logic [WIDTH-1:0]  wdata_q, wdata_d;

   logic [NUM_PORTS-1:0] req_any, pick_oh;
   logic [IW-1:0]        pick_idx, ptr;
   logic                 pick_vld;

   assign req_any = req_read | req_write;

`ifdef ARB_ROUND_ROBIN_EN
   logic [IW-1:0] ptr_q, ptr_d;
   assign ptr = ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (state_q == IDLE && pick_vld)
         ptr_d = (pick_idx == IW'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end
`else
   assign ptr = '0;
`endif

   rr_picker #(.NUM_PORTS(NUM_PORTS), .IW(IW)) u_picker (
      .req_i   (req_any),
      .ptr_i   (ptr),
      .grant_o (pick_oh),
      .idx_o   (pick_idx),
      .vld_o   (pick_vld)
   );

   always_comb begin
      state_d = state_q;
      gidx_d  = gidx_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: if (pick_vld) begin
            state_d = BUSY;
            gidx_d  = pick_idx;
            // Read+write on the same port resolves to a write.
            wr_d    = |(req_write & pick_oh);
            addr_d  = req_address[pick_idx];
            wdata_d = req_wdata[pick_idx];
         end
         BUSY:    if (mem_resp) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         gidx_q  <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         gidx_q  <= gidx_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign mem_read    = (state_q == BUSY) && !wr_q;
   assign mem_write   = (state_q == BUSY) &&  wr_q;
   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;
   assign req_rdata   = mem_rdata;

   always_comb begin
      req_resp = '0;
      if (state_q == BUSY && mem_resp) req_resp[gidx_q] = 1'b1;
   end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Scoreboard bench for mem_arbiter_n; follows ARB_ROUND_ROBIN_EN for grant-order expectations.
module tb_mem_arbiter_n;

   localparam int NP = 3;
   localparam int W  = 256;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NP-1:0]            req_read, req_write, req_resp;
   logic [NP-1:0][31:0]      req_address;
   logic [NP-1:0][W-1:0]     req_wdata;
   logic [W-1:0]             req_rdata, mem_wdata, mem_rdata;
   logic                     mem_read, mem_write, mem_resp;
   logic [31:0]              mem_address;

   typedef struct {
      int         port;
      bit         wr;
      logic [31:0] addr;
      logic [W-1:0] wdata;
   } item_t;

   item_t sb[$];
   int compared = 0;
   int mism     = 0;

   always #5 clk = ~clk;

   mem_arbiter_n #(.NUM_PORTS(NP), .WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req_read(req_read), .req_write(req_write),
      .req_address(req_address), .req_wdata(req_wdata),
      .req_rdata(req_rdata), .req_resp(req_resp),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   function automatic item_t mk(int p, bit wr, logic [31:0] a, logic [W-1:0] d);
      item_t e;
      e.port = p; e.wr = wr; e.addr = a; e.wdata = d;
      return e;
   endfunction

   // Waits for a downstream request, checks it against the scoreboard head,
   // holds it lat cycles, then returns one response. Ends in the DONE cycle.
   task automatic serve(input int budget, input int lat, input bit mutate);
      item_t e;
      int n;
      logic [W-1:0] rd;
      logic [NP-1:0] exp_resp;
      n = 0;
      while (!(mem_read || mem_write) && n < budget) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (!(mem_read || mem_write)) begin
         mism++;
         $display("FAIL serve_timeout: no mem request after %0d cycles", budget);
         return;
      end
      compared++;
      if (sb.size() == 0) begin
         mism++;
         $display("FAIL sb_empty: unexpected request addr=%h", mem_address);
         return;
      end
      e = sb.pop_front();
      compared++;
      if ({mem_write, mem_read} !== (e.wr ? 2'b10 : 2'b01)) begin
         mism++;
         $display("FAIL op: got w/r=%b%b want %b", mem_write, mem_read, e.wr ? 2'b10 : 2'b01);
      end
      compared++;
      if (mem_address !== e.addr) begin
         mism++;
         $display("FAIL addr: got %h want %h (port %0d)", mem_address, e.addr, e.port);
      end
      if (e.wr) begin
         compared++;
         if (mem_wdata !== e.wdata) begin
            mism++;
            $display("FAIL wdata: got %h want %h", mem_wdata[63:0], e.wdata[63:0]);
         end
      end
      if (mutate) begin
         req_wdata[e.port]   = ~req_wdata[e.port];
         req_address[e.port] = req_address[e.port] ^ 32'h0000_FFFF;
      end
      repeat (lat) begin
         @(negedge clk);
         compared++;
         if (mem_address !== e.addr || (e.wr && mem_wdata !== e.wdata)
             || !(mem_read || mem_write)) begin
            mism++;
            $display("FAIL hold: addr=%h want %h wdata=%h want %h", mem_address, e.addr,
                     mem_wdata[63:0], e.wdata[63:0]);
         end
      end
      rd = {8{$urandom}};
      mem_rdata = rd;
      mem_resp  = 1'b1;
      #1;
      exp_resp = '0;
      exp_resp[e.port] = 1'b1;
      compared++;
      if (req_resp !== exp_resp) begin
         mism++;
         $display("FAIL req_resp: got %b want %b", req_resp, exp_resp);
      end
      compared++;
      if (req_rdata !== rd) begin
         mism++;
         $display("FAIL req_rdata: got %h want %h", req_rdata[63:0], rd[63:0]);
      end
      @(negedge clk);
      mem_resp = 1'b0;
      compared++;
      if (mem_read || mem_write || req_resp !== '0) begin
         mism++;
         $display("FAIL done_quiet: r=%b w=%b resp=%b want 0", mem_read, mem_write, req_resp);
      end
   endtask

   task automatic clear_reqs();
      req_read  = '0;
      req_write = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_reqs();
      req_address = '0;
      req_wdata   = '0;
      mem_rdata   = '0;
      mem_resp    = 1'b1;
      repeat (2) @(negedge clk);
      compared++;
      if ({mem_read, mem_write, req_resp} !== '0 || mem_address !== '0 || mem_wdata !== '0) begin
         mism++;
         $display("FAIL reset_state: r=%b w=%b resp=%b addr=%h", mem_read, mem_write,
                  req_resp, mem_address);
      end
      mem_resp = 1'b0;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_read();
      req_address[1] = 32'hABCD_0040;
      req_read[1]    = 1'b1;
      sb.push_back(mk(1, 1'b0, 32'hABCD_0040, '0));
      @(negedge clk);
      serve(0, 3, 1'b0);
      clear_reqs();
      @(negedge clk);
      compared++;
      if (mem_read || mem_write || req_resp !== '0) begin
         mism++;
         $display("FAIL idle_after: r=%b w=%b resp=%b want 0", mem_read, mem_write, req_resp);
      end
   endtask

   task automatic test_write_hold();
      req_address[2] = 32'h0000_1000;
      req_wdata[2]   = {32{8'hA5}} ^ {W{1'b0}};
      req_wdata[2][31:0] = 32'hDEAD_BEEF;
      req_write[2]   = 1'b1;
      sb.push_back(mk(2, 1'b1, 32'h0000_1000, req_wdata[2]));
      serve(4, 3, 1'b1);
      clear_reqs();
      @(negedge clk);
   endtask

   task automatic test_rw_both();
      req_address[0] = 32'h0000_2200;
      req_wdata[0]   = {8{32'h1234_5678}};
      req_read[0]    = 1'b1;
      req_write[0]   = 1'b1;
      sb.push_back(mk(0, 1'b1, 32'h0000_2200, {8{32'h1234_5678}}));
      serve(4, 1, 1'b0);
      clear_reqs();
      @(negedge clk);
   endtask

   task automatic test_reset_mid_busy();
      req_address[1] = 32'h0000_3300;
      req_read[1]    = 1'b1;
      @(negedge clk);
      compared++;
      if (mem_read !== 1'b1) begin
         mism++;
         $display("FAIL busy_pre_reset: mem_read=%b want 1", mem_read);
      end
      mem_resp = 1'b1;
      #3 reset = 1'b1;
      #1;
      compared++;
      if ({mem_read, mem_write, req_resp} !== '0 || mem_address !== '0 || mem_wdata !== '0) begin
         mism++;
         $display("FAIL async_reset: r=%b w=%b resp=%b addr=%h", mem_read, mem_write,
                  req_resp, mem_address);
      end
      mem_resp = 1'b0;
      clear_reqs();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      mem_resp = 1'b1;
      #1;
      compared++;
      if (req_resp !== '0) begin
         mism++;
         $display("FAIL stray_resp: req_resp=%b want 000", req_resp);
      end
      @(negedge clk);
      mem_resp = 1'b0;
      compared++;
      if (mem_read || mem_write || req_resp !== '0) begin
         mism++;
         $display("FAIL stray_idle: r=%b w=%b resp=%b want 0", mem_read, mem_write, req_resp);
      end
   endtask

   task automatic test_contention();
      int order [4];
`ifdef ARB_ROUND_ROBIN_EN
      order = '{0, 1, 2, 0};
`else
      order = '{0, 0, 0, 0};
`endif
      for (int i = 0; i < NP; i++) begin
         req_address[i] = 32'h0000_0100 * (i + 1);
         req_read[i]    = 1'b1;
      end
      for (int k = 0; k < 4; k++)
         sb.push_back(mk(order[k], 1'b0, 32'h0000_0100 * (order[k] + 1), '0));
      for (int k = 0; k < 4; k++) serve(5, 1, 1'b0);
      clear_reqs();
      repeat (2) @(negedge clk);
      compared++;
      if (sb.size() != 0) begin
         mism++;
         $display("FAIL sb_leftover: %0d items want 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_hold();
      test_rw_both();
      test_reset_mid_busy();
      test_contention();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/mem_arbiter_n.md
MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of requesting caches (2..8).
REQ-002 SHALL have parameter WIDTH, default 256, cacheline data width in bits.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_read  input  NUM_PORTS  per-port read request.
REQ-006 SHALL have port req_write  input  NUM_PORTS  per-port write request.
REQ-007 SHALL have port req_address  input  NUM_PORTS x 32  per-port line address.
REQ-008 SHALL have port req_wdata  input  NUM_PORTS x WIDTH  per-port write line.
REQ-009 SHALL have port req_rdata  output  WIDTH  read line, shared by all ports.
REQ-010 SHALL have port req_resp  output  NUM_PORTS  per-port one-cycle completion pulse.
REQ-011 SHALL have port mem_read / mem_write  output  1 each  downstream (L2) request.
REQ-012 SHALL have port mem_address  output  32; mem_wdata  output  WIDTH; mem_rdata  input  WIDTH; mem_resp  input  1.

Function
REQ-013 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-014 IDLE: if any port has read or write asserted, SHALL pick winner g, latch g, op, address, wdata; next state BUSY; else stay IDLE.
REQ-015 BUSY: SHALL drive mem_read/mem_write, mem_address, mem_wdata from the latched values only; request changes are ignored.
REQ-016 BUSY with mem_resp=1: SHALL assert req_resp[g] combinationally the same cycle, pass mem_rdata to req_rdata, deassert mem_read/mem_write the next cycle, go DONE.
REQ-017 DONE: SHALL drive no downstream request and accept no grant for exactly one cycle (requester turnaround), then go IDLE.
REQ-018 Latency: request seen in IDLE at cycle t SHALL produce mem_read/mem_write at t+1; minimum per-transaction occupancy is 3 cycles.
REQ-019 A port with both read and write asserted SHALL be serviced as a write.
REQ-020 A requester that drops its request while BUSY SHALL not abort the transaction; req_resp still pulses.
REQ-021 req_resp SHALL be 0 for all non-granted ports and for all ports outside BUSY; req_rdata SHALL equal mem_rdata at all times.

Reset
REQ-022 Reset SHALL force state IDLE, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, req_resp=0, latched grant=0, priority pointer=0, regardless of transaction in flight.
REQ-023 After reset release, a pending downstream mem_resp SHALL be ignored in IDLE.

Configuration
REQ-024 With ARB_ROUND_ROBIN_EN defined: winner SHALL be first requesting port at or after pointer p (mod NUM_PORTS); on grant to g, p <= (g+1) mod NUM_PORTS.
REQ-025 Without ARB_ROUND_ROBIN_EN: winner SHALL be the lowest-index requesting port (port 0 highest priority); no pointer register is synthesised.

Structure
REQ-026 Package arb_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and default NUM_PORTS/WIDTH constants.
REQ-027 Winner selection SHALL be a sub-module rr_picker (request vector, pointer -> one-hot grant, index, valid).

Verification
REQ-028 Single read port 1, NUM_PORTS=3: mem_read at t+1, address matches, mem_resp at t+4 -> req_resp=3'b010 that cycle, req_rdata=mem_rdata, idle two cycles later.
REQ-029 Ports 0,1,2 all requesting continuously, RR enabled -> grant order 0,1,2,0; RR disabled -> port 0 granted every transaction.
REQ-030 Port 2 write 0x0000_1000 with wdata pattern, port 2 changes wdata in BUSY -> mem_wdata holds original pattern until mem_resp.
REQ-031 Port 0 asserts read and write together -> mem_write=1, mem_read=0.
REQ-032 Reset asserted mid-BUSY -> all outputs 0 asynchronously, pointer 0; stray mem_resp after release -> no req_resp.
